regfile_wb_queue: RTL

- Write-side front end for the 32x32 register file.
- Accepts writeback results from execute/memory units through a valid/ready handshake and buffers them in an in-order queue.
- Drains at most one entry per cycle onto the register file write port (rd/din/rw/enable).
- Provides two forwarding lookups so decode can read results that are still pending and not yet in the register file.

---
 rtl/regfile_wb_queue.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the 32x32 register file: in-order buffering, one drain per cycle, two forwarding ports.
// Optional macro WBQ_COALESCE_EN merges a push into an already-queued entry for the same register.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [4:0]    wb_rd,
  input  logic [31:0]   wb_data,
  input  logic          rf_hold,
  output logic [4:0]    rf_rd,
  output logic [31:0]   rf_din,
  output logic          rf_rw,
  output logic          rf_enable,
  input  logic [4:0]    fwd_rs1,
  input  logic [4:0]    fwd_rs2,
  output logic          fwd_hit1,
  output logic          fwd_hit2,
  output logic [31:0]   fwd_data1,
  output logic [31:0]   fwd_data2,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [4:0]    q_rd   [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [AW-1:0] head_reg;
  logic [AW-1:0] tail_reg;
  logic [AW:0]   count_reg;
  logic [4:0]    rf_rd_reg;
  logic [31:0]   rf_din_reg;
  logic          rf_rw_reg;
  logic          rf_enable_reg;

  logic          pop;
  logic          push;
  logic          push_alloc;
  logic          coal_hit;
  logic [AW-1:0] coal_idx;

  assign pop = (count_reg != '0) && !rf_hold;

`ifdef WBQ_COALESCE_EN
  // The head entry being drained this cycle cannot absorb a new value; it gets a fresh slot instead.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (((AW+1)'(k) < count_reg) && (q_rd[head_reg + k[AW-1:0]] == wb_rd) &&
          (wb_rd != 5'd0) && !(pop && (k == 0))) begin
        coal_hit = 1'b1;
        coal_idx = head_reg + k[AW-1:0];
      end
    end
  end
`else
  assign coal_hit = 1'b0;
  assign coal_idx = '0;
`endif

  assign wb_ready   = reset && ((count_reg < FULL_CNT) || pop || coal_hit);
  assign push       = wb_valid && wb_ready;
  assign push_alloc = push && (wb_rd != 5'd0) && !coal_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      rf_rd_reg     <= 5'd0;
      rf_din_reg    <= 32'd0;
      rf_rw_reg     <= 1'b0;
      rf_enable_reg <= 1'b1;
    end else begin
      if (pop) begin
        rf_rd_reg  <= q_rd[head_reg];
        rf_din_reg <= q_data[head_reg];
        head_reg   <= head_reg + 1'b1;
      end
      if (push_alloc) begin
        tail_reg <= tail_reg + 1'b1;
      end
      rf_rw_reg     <= pop;
      count_reg     <= count_reg + (AW+1)'(push_alloc) - (AW+1)'(pop);
      rf_enable_reg <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_alloc) begin
      q_rd[tail_reg]   <= wb_rd;
      q_data[tail_reg] <= wb_data;
    end else if (push && coal_hit) begin
      q_data[coal_idx] <= wb_data;
    end
  end

  assign rf_rd     = rf_rd_reg;
  assign rf_din    = rf_din_reg;
  assign rf_rw     = rf_rw_reg;
  assign rf_enable = rf_enable_reg;
  assign count     = count_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic [4:0]  rs;
    logic        hit;
    logic [31:0] data;

    // Scan oldest to youngest so the youngest match wins; the output stage has lowest priority.
    always_comb begin
      hit  = 1'b0;
      data = 32'd0;
      if (rf_rw_reg && (rf_rd_reg == rs)) begin
        hit  = 1'b1;
        data = rf_din_reg;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (((AW+1)'(k) < count_reg) && (q_rd[head_reg + k[AW-1:0]] == rs)) begin
          hit  = 1'b1;
          data = q_data[head_reg + k[AW-1:0]];
        end
      end
      if (rs == 5'd0) begin
        hit  = 1'b0;
        data = 32'd0;
      end
    end

    if (gi == 0) begin : g_port1
      assign rs        = fwd_rs1;
      assign fwd_hit1  = hit;
      assign fwd_data1 = data;
    end else begin : g_port2
      assign rs        = fwd_rs2;
      assign fwd_hit2  = hit;
      assign fwd_data2 = data;
    end
  end

endmodule
